// File: rtl/seq_matcher_pkg.sv
// Shared constants for the seq_matcher serial pattern detector.
// Width limits are checked at elaboration by the modules that use them.
package seq_matcher_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    // Sized for the widest legal pattern so every instance can share one fill counter width.
    localparam int FILL_W = $clog2(PAT_W_MAX + 1);

    function automatic bit pat_w_legal(input int w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction

    function automatic bit cnt_w_legal(input int w);
        return (w >= CNT_W_MIN) && (w <= CNT_W_MAX);
    endfunction

endpackage

// File: rtl/seq_matcher_sat_counter.sv
// CNT_W-bit saturating up-counter with synchronous clear; sat flags all-ones.
// Only instantiated by seq_matcher when SEQ_MATCHER_CNT_EN is defined.
module sat_counter
    import seq_matcher_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    if (!cnt_w_legal(CNT_W)) begin : g_bad_cnt_w
        $error("sat_counter: CNT_W must lie in %0d..%0d", CNT_W_MIN, CNT_W_MAX);
    end

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign sat = (cnt_reg == {CNT_W{1'b1}});
    assign cnt = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && !sat) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/seq_matcher.sv
// Serial pattern detector: compares the last PAT_W valid bits with a loadable pattern.
// Define SEQ_MATCHER_CNT_EN to build the saturating match counter; otherwise it reads 0.
module seq_matcher
    import seq_matcher_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter int             CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             inp,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat,
    input  logic             overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
        $error("seq_matcher: PAT_W must lie in %0d..%0d", PAT_W_MIN, PAT_W_MAX);
    end

    if (!cnt_w_legal(CNT_W)) begin : g_bad_cnt_w
        $error("seq_matcher: CNT_W must lie in %0d..%0d", CNT_W_MIN, CNT_W_MAX);
    end

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // The oldest bit of the window is always shifted out, so only PAT_W-1 bits persist.
    logic [PAT_W-2:0]  hist_reg, hist_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [PAT_W-1:0]  pat_reg,  pat_next;
    logic              match_reg, match_next;

    logic [PAT_W-1:0]  window;
    logic [FILL_W-1:0] fill_sat;
    logic              hit;

    assign window[0] = inp;
    for (genvar gi = 1; gi < PAT_W; gi++) begin : g_window
        assign window[gi] = hist_reg[gi-1];
    end

    assign fill_sat = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
    assign hit      = (fill_sat == FILL_FULL) && (window == pat_reg);

    always_comb begin
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        pat_next   = pat_reg;
        match_next = 1'b0;
        if (pat_load) begin
            pat_next  = pat;
            hist_next = '0;
            fill_next = '0;
        end else if (in_valid) begin
            hist_next  = window[PAT_W-2:0];
            match_next = hit;
            fill_next  = (hit && !overlap) ? '0 : fill_sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg  <= '0;
            fill_reg  <= '0;
            pat_reg   <= PAT_RST;
            match_reg <= 1'b0;
        end else begin
            hist_reg  <= hist_next;
            fill_reg  <= fill_next;
            pat_reg   <= pat_next;
            match_reg <= match_next;
        end
    end

    assign match = match_reg;

`ifdef SEQ_MATCHER_CNT_EN
    logic cnt_inc;
    logic cnt_clr;

    assign cnt_clr = pat_load;
    assign cnt_inc = in_valid && !pat_load && hit;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );
`else
    assign match_cnt = '0;
    assign cnt_sat   = 1'b0;
`endif

endmodule
